// File: rtl/cpu_pkg.sv
// Shared types and constants for the 10-bit bus processor.
// Used by control_unit and by the ALU and output-logic wrappers.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_MOV  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam int OP_MSB = 9;
  localparam int OP_LSB = 6;
  localparam int RX_MSB = 5;
  localparam int RX_LSB = 3;
  localparam int RY_MSB = 2;
  localparam int RY_LSB = 0;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// Register index to one-hot decoder with enable.
// Output is all-zero when disabled.
module dec3to8 #(
  parameter int N = 8
) (
  input  logic                 en,
  input  logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Sequencing controller: latches an instruction on EXEC and walks T0..T3,
// decoding register, ALU and bus-driver controls from (TIME, IR).
//
// state | meaning
// T0    | idle, all controls 0, accepts EXEC
// T1    | LOAD/MOV transfer, ALU operand A load, or illegal-op NOP
// T2    | ALU op: Ry onto BUS, result into G
// T3    | ALU op: G onto BUS, written back to Rx
module control_unit
  import cpu_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EXEC,
  input  logic [9:0]      INSTR,
  output logic [1:0]      TIME,
  output logic            DONE,
  output logic [9:0]      IR,
  output logic            EXT_OE,
  output logic [NREG-1:0] ROUT,
  output logic [NREG-1:0] RIN,
  output logic            A_LD,
  output logic            G_LD,
  output logic            G_OE,
  output logic [2:0]      ALU_OP
);

  localparam int RW = $clog2(NREG);

  tstep_t      state, state_nxt;
  logic [9:0]  ir_q, ir_nxt;
  logic        done_q, done_nxt;
  logic [3:0]  op;
  logic [3:0]  op_off;
  logic [RW-1:0] rx, ry;
  logic [RW-1:0] rout_idx, rin_idx;
  logic        rout_en, rin_en;
  logic        last;

  assign op     = ir_q[OP_MSB:OP_LSB];
  assign op_off = op - 4'd2;
  assign rx     = ir_q[RX_MSB:RX_LSB];
  assign ry     = ir_q[RY_MSB:RY_LSB];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= T0;
      ir_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ir_q   <= ir_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir_q;
    done_nxt  = done_q;
    EXT_OE    = 1'b0;
    A_LD      = 1'b0;
    G_LD      = 1'b0;
    G_OE      = 1'b0;
    ALU_OP    = 3'd0;
    rout_en   = 1'b0;
    rout_idx  = rx;
    rin_en    = 1'b0;
    rin_idx   = rx;
    last      = 1'b0;

    case (state)
      T0: begin
        if (EXEC) begin
          ir_nxt    = INSTR;
          done_nxt  = 1'b0;
          state_nxt = T1;
        end
      end
      T1: begin
        case (op)
          OP_LOAD: begin
            EXT_OE = 1'b1;
            rin_en = 1'b1;
            last   = 1'b1;
          end
          OP_MOV: begin
            rout_en  = 1'b1;
            rout_idx = ry;
            rin_en   = 1'b1;
            last     = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            rout_en   = 1'b1;
            A_LD      = 1'b1;
            state_nxt = T2;
          end
          default: last = 1'b1;
        endcase
      end
      T2: begin
        if (is_alu(op)) begin
          rout_en   = 1'b1;
          rout_idx  = ry;
          G_LD      = 1'b1;
          ALU_OP    = alu_op_t'(op_off[2:0]);
          state_nxt = T3;
        end else begin
          last = 1'b1;
        end
      end
      T3: begin
        if (is_alu(op)) begin
          G_OE   = 1'b1;
          rin_en = 1'b1;
        end
        last = 1'b1;
      end
      default: last = 1'b1;
    endcase

    // Every path out of T1..T3 ends here; TIME never counts past T3.
    if (last) begin
      state_nxt = T0;
      done_nxt  = 1'b1;
    end
  end

  dec3to8 #(.N(NREG)) u_dec_rout (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (ROUT)
  );

  dec3to8 #(.N(NREG)) u_dec_rin (
    .en     (rin_en),
    .idx    (rin_idx),
    .onehot (RIN)
  );

  assign TIME = state;
  assign DONE = done_q;
  assign IR   = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected control vectors
// are queued when an instruction is issued and compared as the DUT steps.
module tb_control_unit;
  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EXEC = 1'b0;
  logic [9:0] INSTR = '0;
  logic [1:0] TIME;
  logic       DONE;
  logic [9:0] IR;
  logic       EXT_OE;
  logic [7:0] ROUT;
  logic [7:0] RIN;
  logic       A_LD;
  logic       G_LD;
  logic       G_OE;
  logic [2:0] ALU_OP;

  control_unit #(.NREG(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EXEC   (EXEC),
    .INSTR  (INSTR),
    .TIME   (TIME),
    .DONE   (DONE),
    .IR     (IR),
    .EXT_OE (EXT_OE),
    .ROUT   (ROUT),
    .RIN    (RIN),
    .A_LD   (A_LD),
    .G_LD   (G_LD),
    .G_OE   (G_OE),
    .ALU_OP (ALU_OP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] t;
    logic       done;
    logic [9:0] ir;
    logic       ext;
    logic [7:0] rout;
    logic [7:0] rin;
    logic       a;
    logic       g;
    logic       goe;
    logic [2:0] alu;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t blank(input logic [1:0] t, input logic [9:0] ir, input logic done);
    exp_t e;
    e.t = t; e.ir = ir; e.done = done;
    e.ext = 1'b0; e.rout = '0; e.rin = '0;
    e.a = 1'b0; e.g = 1'b0; e.goe = 1'b0; e.alu = '0;
    return e;
  endfunction

  task automatic cmp(input exp_t e, input string tag);
    chk({tag, ".time"},   32'(TIME),   32'(e.t));
    chk({tag, ".done"},   32'(DONE),   32'(e.done));
    chk({tag, ".ir"},     32'(IR),     32'(e.ir));
    chk({tag, ".ext_oe"}, 32'(EXT_OE), 32'(e.ext));
    chk({tag, ".rout"},   32'(ROUT),   32'(e.rout));
    chk({tag, ".rin"},    32'(RIN),    32'(e.rin));
    chk({tag, ".a_ld"},   32'(A_LD),   32'(e.a));
    chk({tag, ".g_ld"},   32'(G_LD),   32'(e.g));
    chk({tag, ".g_oe"},   32'(G_OE),   32'(e.goe));
    chk({tag, ".alu_op"}, 32'(ALU_OP), 32'(e.alu));
  endtask

  // Reference sequence per opcode, written from the instruction table.
  task automatic push_model(input logic [9:0] instr);
    logic [3:0] op;
    logic [7:0] bx, by;
    exp_t e;
    op = instr[9:6];
    bx = 8'd1 << instr[5:3];
    by = 8'd1 << instr[2:0];
    if (op == 4'd0) begin
      e = blank(2'd1, instr, 1'b0); e.ext = 1'b1; e.rin = bx; sb.push_back(e);
    end else if (op == 4'd1) begin
      e = blank(2'd1, instr, 1'b0); e.rout = by; e.rin = bx; sb.push_back(e);
    end else if (op <= 4'd7) begin
      e = blank(2'd1, instr, 1'b0); e.rout = bx; e.a = 1'b1; sb.push_back(e);
      e = blank(2'd2, instr, 1'b0); e.rout = by; e.g = 1'b1; e.alu = 3'(op - 4'd2); sb.push_back(e);
      e = blank(2'd3, instr, 1'b0); e.goe = 1'b1; e.rin = bx; sb.push_back(e);
    end else begin
      sb.push_back(blank(2'd1, instr, 1'b0));
    end
    sb.push_back(blank(2'd0, instr, 1'b1));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one instruction from T0. inject_at: cycle index after which a
  // stray EXEC(3FF) is driven; abort_at: cycle index after which RST hits.
  task automatic run_instr(input logic [9:0] instr, input string tag,
                           input int inject_at, input int abort_at);
    exp_t e;
    int   k;
    INSTR = instr;
    EXEC  = 1'b1;
    push_model(instr);
    k = 0;
    while (sb.size() > 0) begin
      step();
      EXEC = 1'b0;
      e = sb.pop_front();
      cmp(e, $sformatf("%s[%0d]", tag, k));
      if (k == inject_at) begin
        INSTR = 10'h3FF;
        EXEC  = 1'b1;
      end
      if (k == abort_at) begin
        #2;
        RST = 1'b1;
        #1;
        cmp(blank(2'd0, 10'h000, 1'b0), {tag, ".abort"});
        sb.delete();
      end
      k++;
    end
  endtask

  // Bus-safety and one-hot invariants, sampled every cycle away from the edge.
  always @(negedge CLK) begin
    chk("bus_inv", 32'($countones({EXT_OE, ROUT, G_OE}) <= 1), 32'd1);
    chk("rin_onehot0", 32'($onehot0(RIN)), 32'd1);
    if (TIME != 2'd2) chk("alu_op_idle", 32'(ALU_OP), 32'd0);
  end

  initial begin
    logic [9:0] r;

    #23;
    cmp(blank(2'd0, 10'h000, 1'b0), "reset");
    RST = 1'b0;
    step(); cmp(blank(2'd0, 10'h000, 1'b0), "idle0");
    step(); cmp(blank(2'd0, 10'h000, 1'b0), "idle1");

    run_instr(10'h018, "load_r3", -1, -1);

    #2; RST = 1'b1; #1;
    cmp(blank(2'd0, 10'h000, 1'b0), "reset_mid");
    step();
    #3; RST = 1'b0;
    step(); cmp(blank(2'd0, 10'h000, 1'b0), "post_rst");

    run_instr(10'h08A, "add_r1_r2", -1, -1);
    run_instr(10'h068, "mov_b2b", -1, -1);
    run_instr(10'h08A, "exec_ign", 1, -1);
    run_instr(10'h3C0, "illegal", -1, -1);
    run_instr(10'h1F7, "not_r6_r7", -1, -1);
    run_instr(10'h092, "add_r2_r2", -1, -1);

    for (int i = 0; i < 8; i++) begin
      r = 10'($urandom_range(0, 1023));
      run_instr(r, $sformatf("rnd%0d", i), -1, -1);
    end

    run_instr(10'h0E5, "sub_abort", 1, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abort_rin", 32'(RIN), 32'd0);
      chk("abort_time", 32'(TIME), 32'd0);
    end
    #3;
    RST = 1'b0;
    run_instr(10'h02A, "load_after_rst", -1, -1);

    step(); cmp(blank(2'd0, 10'h02A, 1'b1), "done_sticky");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
